class_vec_search: RTL and testbench

Associative-search reader for the class hypervector store. On `start`, it walks every class and frame of the class-vector generator by driving its `frame_id`/`frame_index` address. Each returned 64-bit frame is XORed with the matching slice of a held query hypervector, and the Hamming distance is accumulated per class. The block reports the class with minimum distance, so it closes the inference path behind the encoder.

---
 rtl/class_vec_search.sv | 111 +++++++++++
 tb/tb_class_vec_search.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/class_vec_search.sv
// Associative search over the class hypervector store.
// Scans every class frame, accumulates Hamming distance, reports the nearest class.
module class_vec_search #(
  parameter int FRAME_W     = 64,
  parameter int NUM_FRAMES  = 3,
  parameter int NUM_CLASSES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [FRAME_W*NUM_FRAMES-1:0] query_hv,
  output logic [2:0]                    frame_id,
  output logic [1:0]                    frame_index,
  input  logic [FRAME_W-1:0]            class_vec_in,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    pred_class,
  output logic [7:0]                    pred_dist
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state;

  logic [7:0]         acc;
  logic [7:0]         best_dist;
  logic [2:0]         best_class;
  logic [FRAME_W-1:0] diff;
  logic [6:0]         pc;
  logic [7:0]         total;
  logic               last_frame;
  logic               last_class;
  logic               take;
  logic [7:0]         nxt_dist;
  logic [2:0]         nxt_class;

  always_comb begin
    diff = class_vec_in
         ^ query_hv[int'(frame_index)*FRAME_W +: FRAME_W];
    pc = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      pc = pc + 7'(diff[i]);
    end
    total      = acc + 8'(pc);
    last_frame = frame_index == 2'(NUM_FRAMES - 1);
    last_class = frame_id == 3'(NUM_CLASSES - 1);
    // strict less-than keeps the lowest class index on ties
    take       = last_frame
               && (frame_id == 3'd0 || total < best_dist);
    nxt_dist   = take ? total : best_dist;
    nxt_class  = take ? frame_id : best_class;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_id    <= '0;
      frame_index <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pred_class  <= '0;
      pred_dist   <= '0;
      acc         <= '0;
      best_dist   <= '0;
      best_class  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            acc        <= '0;
            best_dist  <= '0;
            best_class <= '0;
          end
        end
        SCAN: begin
          acc        <= last_frame ? 8'd0 : total;
          best_dist  <= nxt_dist;
          best_class <= nxt_class;
          if (last_frame) begin
            frame_index <= '0;
            if (last_class) begin
              frame_id   <= '0;
              state      <= DONE;
              done       <= 1'b1;
              pred_class <= nxt_class;
              pred_dist  <= nxt_dist;
            end else begin
              frame_id <= frame_id + 3'd1;
            end
          end else begin
            frame_index <= frame_index + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_vec_search.sv
// Directed bench for class_vec_search.
// Generator is modelled in-bench: hashed frames or simple stubs.
module tb_class_vec_search;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [191:0] query_hv;
  logic [2:0]   frame_id;
  logic [1:0]   frame_index;
  logic [63:0]  class_vec_in;
  logic         busy;
  logic         done;
  logic [2:0]   pred_class;
  logic [7:0]   pred_dist;

  int n_chk = 0;
  int n_err = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  class_vec_search dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .query_hv     (query_hv),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .busy         (busy),
    .done         (done),
    .pred_class   (pred_class),
    .pred_dist    (pred_dist)
  );

  function automatic logic [63:0] gen(input int id, input int idx);
    return 64'h9E37_79B9_7F4A_7C15 * 64'(id * 4 + idx + 1);
  endfunction

  always_comb begin
    class_vec_in = '0;
    case (mode)
      0: class_vec_in = gen(int'(frame_id), int'(frame_index));
      2: class_vec_in = (frame_id == 3'd3) ? '1 : '0;
      default: class_vec_in = '0;
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input string tag, input int ec, input int ed);
    int lat;
    int bad;
    lat = 0;
    bad = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k <= 24) begin
        if (int'(frame_id) != (k - 1) / 3 ||
            int'(frame_index) != (k - 1) % 3 || !busy)
          bad++;
      end
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 24);
    chk({tag, "_cls"}, int'(pred_class), ec);
    chk({tag, "_dist"}, int'(pred_dist), ed);
    chk({tag, "_addr"}, bad, 0);
    step();
    chk({tag, "_idle"}, int'({busy, done, frame_id, frame_index}), 0);
  endtask

  logic [191:0] q4;

  initial begin
    int ndone;
    int t1;
    int t2;
    int unstable;
    q4       = {gen(4, 2), gen(4, 1), gen(4, 0)};
    rst_n    = 1'b0;
    start    = 1'b0;
    query_hv = '0;
    #22;
    chk("rst_out", int'({busy, done, pred_class, pred_dist}), 0);
    chk("rst_addr", int'({frame_id, frame_index}), 0);
    rst_n = 1'b1;
    step();

    mode     = 0;
    query_hv = q4;
    run_search("match4", 4, 0);

    mode     = 1;
    query_hv = '0;
    run_search("tie0", 0, 0);

    mode     = 2;
    query_hv = '1;
    run_search("ones3", 3, 0);

    mode     = 1;
    query_hv = '1;
    run_search("max192", 0, 192);

    // reset in the middle of a scan
    mode     = 0;
    query_hv = q4;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", int'({busy, done, pred_class, pred_dist}), 0);
    chk("mid_addr", int'({frame_id, frame_index}), 0);
    step();
    rst_n = 1'b1;
    step();
    run_search("after_rst", 4, 0);

    // start pulse mid-scan is ignored
    mode     = 1;
    query_hv = '1;
    ndone    = 0;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      start = (k == 5 || k == 6);
      step();
      if (done) ndone++;
    end
    start = 1'b0;
    chk("pulse_ndone", ndone, 1);
    chk("pulse_dist", int'(pred_dist), 192);

    // start held high: back-to-back searches
    mode     = 2;
    query_hv = '1;
    t1       = -1;
    t2       = -1;
    unstable = 0;
    start    = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      step();
      if (done) begin
        if (t1 < 0) t1 = k;
        else begin
          t2 = k;
          break;
        end
      end else if (t1 >= 0) begin
        if (pred_class != 3'd3 || pred_dist != 8'd0) unstable++;
      end
    end
    start = 1'b0;
    chk("hold_gap", t2 - t1, 26);
    chk("hold_stable", unstable, 0);
    chk("hold_cls", int'(pred_class), 3);
    step();
    step();
    chk("hold_end", int'({busy, done}), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
